serial_cmp4: RTL and testbench

SERIAL_CMP4 -- requirements
Module: serial_cmp4

---
 rtl/serial_cmp4_pkg.sv | 12 +
 rtl/serial_cmp4_bit_cell.sv | 27 ++
 rtl/serial_cmp4.sv | 110 +++++++++++
 tb/tb_serial_cmp4.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_cmp4_pkg.sv
// rtl/serial_cmp4_pkg.sv - shared state encoding and defaults for the serial comparator
package serial_cmp4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_cmp4_bit_cell.sv
// rtl/serial_cmp4_bit_cell.sv - one bit-pair compare step with sticky decided flag
module cmp_bit_cell
  import serial_cmp4_pkg::*;
(
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  logic decided_i,
  input  logic lt_i,
  input  logic gt_i,
  output logic decided_o,
  output logic lt_o,
  output logic gt_o
);

  always_comb begin
    decided_o = decided_i;
    lt_o      = lt_i;
    gt_o      = gt_i;
    // First differing bit (MSB-first) settles the relation for good
    if (!decided_i && (a_bit_i != b_bit_i)) begin
      decided_o = 1'b1;
      lt_o      = b_bit_i;
      gt_o      = a_bit_i;
    end
  end

endmodule

// File: rtl/serial_cmp4.sv
// rtl/serial_cmp4.sv - bit-serial MSB-first unsigned comparator with valid/ready handshakes
module serial_cmp4
  import serial_cmp4_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             cell_dec, cell_lt, cell_gt;

  cmp_bit_cell u_cell (
    .a_bit_i   (a_q[WIDTH-1]),
    .b_bit_i   (b_q[WIDTH-1]),
    .decided_i (dec_q),
    .lt_i      (lt_q),
    .gt_i      (gt_q),
    .decided_o (cell_dec),
    .lt_o      (cell_lt),
    .gt_o      (cell_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = data_a;
          b_d     = data_b;
          cnt_d   = CW'(WIDTH - 1);
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        dec_d = cell_dec;
        lt_d  = cell_lt;
        gt_d  = cell_gt;
        // Counter stops at zero; that is the exit, never a wrap
        if ((cnt_q == '0) || (EARLY_EXIT && cell_dec)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lt        = out_valid & lt_q;
  assign eq        = out_valid & ~dec_q;
  assign gt        = out_valid & gt_q;

endmodule

// File: tb/tb_serial_cmp4.sv
// tb/tb_serial_cmp4.sv - directed and exhaustive bench for serial_cmp4 at both exit modes
module tb_serial_cmp4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid;
  logic [1:0]   out_ready;
  logic [W-1:0] data_a, data_b;
  logic [1:0]   in_ready, out_valid, lt, eq, gt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_cmp4 #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .lt(lt[0]), .eq(eq[0]), .gt(gt[0])
  );

  serial_cmp4 #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .lt(lt[1]), .eq(eq[1]), .gt(gt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the chosen instance idle; cycle 0 is the accept cycle
  task automatic run_op(input int ee, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2:0] flags, output int cyc);
    data_a       = a;
    data_b       = b;
    in_valid[ee] = 1'b1;
    @(negedge clk);
    in_valid[ee] = 1'b0;
    cyc = 1;
    while (!out_valid[ee] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    flags = {lt[ee], eq[ee], gt[ee]};
    if (out_ready[ee]) @(negedge clk);
  endtask

  function automatic logic [2:0] exp_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a < b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int exp_cyc(input int ee, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    if (ee == 0) return W + 1;
    for (int k = 0; k < W; k++) begin
      if (x[W-1-k]) return k + 2;
    end
    return W + 1;
  endfunction

  logic [2:0] f;
  int         c;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    data_a    = '0;
    data_b    = '0;
    #1;
    check("rst_in_ready", in_ready, 2'b11);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_flags", {lt, eq, gt}, 6'b0);

    // Accept on the very first edge after release: A=3, B=9
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 4'd3, 4'd9, f, c);
    check("s1_flags", f, 3'b100);
    check("s1_cyc", c, 5);
    check("s1_one_cycle", out_valid[0], 1'b0);

    // Equal operands take the full length even with early exit
    run_op(0, 4'd9, 4'd9, f, c);
    check("s2_ee0_flags", f, 3'b010);
    check("s2_ee0_cyc", c, 5);
    run_op(1, 4'd9, 4'd9, f, c);
    check("s2_ee1_flags", f, 3'b010);
    check("s2_ee1_cyc", c, 5);

    // MSB differs: early exit after one SHIFT cycle
    run_op(1, 4'd12, 4'd3, f, c);
    check("s3_ee1_flags", f, 3'b001);
    check("s3_ee1_cyc", c, 2);
    run_op(0, 4'd12, 4'd3, f, c);
    check("s3_ee0_flags", f, 3'b001);
    check("s3_ee0_cyc", c, 5);

    // Back-pressure: result held, new operands ignored
    out_ready[0] = 1'b0;
    run_op(0, 4'd5, 4'd6, f, c);
    check("s4_flags", f, 3'b100);
    check("s4_cyc", c, 5);
    data_a = 4'd15;
    data_b = 4'd0;
    for (int i = 0; i < 6; i++) begin
      in_valid[0] = i[0];
      @(negedge clk);
      check("s4_hold_valid", out_valid[0], 1'b1);
      check("s4_hold_flags", {lt[0], eq[0], gt[0]}, 3'b100);
      check("s4_hold_in_ready", in_ready[0], 1'b0);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("s4_release_in_ready", in_ready[0], 1'b1);
    check("s4_release_out_valid", out_valid[0], 1'b0);
    run_op(0, 4'd2, 4'd2, f, c);
    check("s4_after_flags", f, 3'b010);
    check("s4_after_cyc", c, 5);

    // Reset mid-SHIFT abandons the operation
    data_a      = 4'd1;
    data_b      = 4'd2;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("s5_busy", in_ready[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("s5_rst_in_ready", in_ready[0], 1'b1);
    check("s5_rst_out_valid", out_valid[0], 1'b0);
    check("s5_rst_flags", {lt[0], eq[0], gt[0]}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 4'd15, 4'd0, f, c);
    check("s5_flags", f, 3'b001);
    check("s5_cyc", c, 5);

    // Exhaustive sweep at both exit settings
    for (int ee = 0; ee < 2; ee++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(ee, W'(a), W'(b), f, c);
          check("sweep_flags", f, exp_flags(W'(a), W'(b)));
          check("sweep_cyc", c, exp_cyc(ee, W'(a), W'(b)));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
